// File: rtl/doom58_pkg.sv
// Shared constants and types for the raycaster's drawing blocks.
package doom58_pkg;

  // Pixel grid of the VGA adapter. Column indices at or beyond SCREEN_W are off-screen.
  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

  typedef logic [2:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } drawer_state_t;

  localparam colour_t DEFAULT_CEIL_COLOUR  = 3'b001;
  localparam colour_t DEFAULT_FLOOR_COLOUR = 3'b010;

  // Picks the colour of one row given the wall span.
  // An empty wall has bottom = top - 1, so no row lands inside it.
  function automatic colour_t pickColour(
    input logic [6:0] row,
    input logic [6:0] top,
    input logic [6:0] bottom,
    input colour_t    wallColour,
    input colour_t    ceilColour,
    input colour_t    floorColour
  );
    colour_t result;
    if (row < top) begin
      result = ceilColour;
    end else if (row > bottom) begin
      result = floorColour;
    end else begin
      result = wallColour;
    end
    return result;
  endfunction

endpackage

// File: rtl/wall_span.sv
// Maps a requested wall height to the first and last wall rows of a column.
// Purely combinational so sprite and column renderers can share it.
module wall_span
  import doom58_pkg::*;
(
  input  logic [6:0] i_height,
  output logic [6:0] o_top,
  output logic [6:0] o_bottom
);

  logic [6:0] w_height;
  logic [6:0] w_top;

  // Clamp the height to the screen, then centre the wall vertically.
  // A zero height gives top = 60, bottom = 59: an empty span between ceiling and floor.
  always_comb begin
    w_height = (i_height > SCREEN_H) ? SCREEN_H : i_height;
    w_top    = (SCREEN_H - w_height) >> 1;
    o_top    = w_top;
    o_bottom = w_top + w_height - 7'd1;
  end

endmodule

// File: rtl/column_drawer.sv
// Draws one full screen column per request: ceiling, centred wall slice, floor.
// Emits one pixel write per clock to the VGA adapter.
module column_drawer
  import doom58_pkg::*;
#(
  parameter colour_t CEIL_COLOUR  = DEFAULT_CEIL_COLOUR,
  parameter colour_t FLOOR_COLOUR = DEFAULT_FLOOR_COLOUR
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_height,
  input  logic [2:0] req_colour,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);

  localparam logic [6:0] LAST_ROW = SCREEN_H - 7'd1;

  drawer_state_t r_state;
  logic [7:0]    r_x;
  logic [6:0]    r_row;
  logic [6:0]    r_top;
  logic [6:0]    r_bottom;
  colour_t       r_wallColour;
  logic          r_reqReady;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_vgaX;
  logic [6:0]    r_vgaY;
  colour_t       r_vgaColour;
  logic          r_vgaWrite;

  logic [6:0]    w_top;
  logic [6:0]    w_bottom;
  logic [6:0]    w_nextRow;

  wall_span u_wallSpan (
    .i_height (req_height),
    .o_top    (w_top),
    .o_bottom (w_bottom)
  );

  assign w_nextRow = r_row + 7'd1;

  // Control FSM with registered outputs. Row 0 is presented on the cycle right after
  // acceptance, so its colour comes from the live span, not the latched one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_row        <= '0;
      r_top        <= '0;
      r_bottom     <= '0;
      r_wallColour <= '0;
      r_reqReady   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_vgaX       <= '0;
      r_vgaY       <= '0;
      r_vgaColour  <= '0;
      r_vgaWrite   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done     <= 1'b0;
          r_vgaWrite <= 1'b0;
          if (req_valid && r_reqReady) begin
            r_x          <= req_x;
            r_wallColour <= req_colour;
            r_top        <= w_top;
            r_bottom     <= w_bottom;
            r_row        <= '0;
            r_reqReady   <= 1'b0;
            r_busy       <= 1'b1;
            if (req_x >= SCREEN_W) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= DRAW;
              r_vgaWrite  <= 1'b1;
              r_vgaX      <= req_x;
              r_vgaY      <= '0;
              r_vgaColour <= pickColour(7'd0, w_top, w_bottom, req_colour,
                                        CEIL_COLOUR, FLOOR_COLOUR);
            end
          end
        end

        DRAW: begin
          if (r_row == LAST_ROW) begin
            r_state    <= DONE;
            r_vgaWrite <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_row       <= w_nextRow;
            r_vgaWrite  <= 1'b1;
            r_vgaX      <= r_x;
            r_vgaY      <= w_nextRow;
            r_vgaColour <= pickColour(w_nextRow, r_top, r_bottom, r_wallColour,
                                      CEIL_COLOUR, FLOOR_COLOUR);
          end
        end

        DONE: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_reqReady <= 1'b1;
          r_vgaWrite <= 1'b0;
        end

        default: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_reqReady <= 1'b1;
          r_vgaWrite <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_reqReady;
  assign busy       = r_busy;
  assign done       = r_done;
  assign vga_x      = r_vgaX;
  assign vga_y      = r_vgaY;
  assign vga_colour = r_vgaColour;
  assign vga_write  = r_vgaWrite;

endmodule

// File: tb/tb_column_drawer.sv
// Directed bench for column_drawer: checks every pixel write of several columns,
// the handshake timing, off-screen requests, back-to-back requests and mid-column reset.
module tb_column_drawer;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_height;
  logic [2:0] req_colour;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_write;

  int total = 0;
  int bad   = 0;

  column_drawer dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_height (req_height),
    .req_colour (req_colour),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write)
  );

  // 100 MHz-style clock; the DUT acts on posedge, the bench samples on negedge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference colour for a row, derived from the clamped and centred wall.
  function automatic logic [2:0] expColour(input int row, input int h, input logic [2:0] c);
    int hc;
    int top;
    int bot;
    hc  = (h > 120) ? 120 : h;
    top = (120 - hc) / 2;
    bot = top + hc - 1;
    if (row < top) return 3'b001;
    if (row > bot) return 3'b010;
    return c;
  endfunction

  // Presents a request and returns at the negedge of cycle N+1 (first row visible).
  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] h,
                               input logic [2:0] c, input bit hold);
    @(negedge clock);
    checkOutput("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_x      = x;
    req_height = h;
    req_colour = c;
    @(posedge clock);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
  endtask

  // Checks rows 0..119, the done cycle and the return to idle.
  // Entered at the negedge of cycle N+1; leaves at the negedge of cycle N+122.
  task automatic checkColumn(input logic [7:0] x, input int h, input logic [2:0] c);
    logic [18:0] exp;
    logic [18:0] obs;
    for (int i = 0; i < 120; i++) begin
      if (i > 0) @(negedge clock);
      exp = {1'b1, x, 7'(i), expColour(i, h, c)};
      obs = {vga_write, vga_x, vga_y, vga_colour};
      checkOutput("row_write", {13'd0, obs}, {13'd0, exp});
      if (i == 0 || i == 119) begin
        checkOutput("busy_in_draw", {30'd0, busy, req_ready}, {30'd0, 2'b10});
      end
      if (done) checkOutput("done_during_draw", {31'd0, done}, 32'd0);
    end
    @(negedge clock);
    checkOutput("done_cycle", {28'd0, done, vga_write, busy, req_ready}, {28'd0, 4'b1010});
    checkOutput("hold_after_draw", {17'd0, vga_x, vga_y}, {17'd0, x, 7'd119});
    @(negedge clock);
    checkOutput("idle_after_done", {28'd0, done, vga_write, busy, req_ready}, {28'd0, 4'b0001});
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_x      = '0;
    req_height = '0;
    req_colour = '0;

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs",
                {10'd0, req_ready, busy, done, vga_write, vga_x, vga_y, vga_colour},
                {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0});
    reset = 1'b0;

    // Nominal column: wall rows 40..79
    applyStimulus(8'd10, 7'd40, 3'b100, 1'b0);
    checkColumn(8'd10, 40, 3'b100);

    // Clamped height fills the column; rightmost visible x
    applyStimulus(8'd159, 7'd127, 3'b011, 1'b0);
    checkColumn(8'd159, 127, 3'b011);

    // Zero, one, full-minus-one and exactly-full heights
    applyStimulus(8'd0, 7'd0, 3'b101, 1'b0);
    checkColumn(8'd0, 0, 3'b101);
    applyStimulus(8'd30, 7'd1, 3'b110, 1'b0);
    checkColumn(8'd30, 1, 3'b110);
    applyStimulus(8'd100, 7'd119, 3'b111, 1'b0);
    checkColumn(8'd100, 119, 3'b111);
    applyStimulus(8'd5, 7'd120, 3'b000, 1'b0);
    checkColumn(8'd5, 120, 3'b000);

    // Off-screen column: done at N+1, ready again at N+2, no writes
    applyStimulus(8'd160, 7'd50, 3'b100, 1'b0);
    checkOutput("offscreen_done", {28'd0, done, vga_write, busy, req_ready}, {28'd0, 4'b1010});
    @(negedge clock);
    checkOutput("offscreen_idle", {28'd0, done, vga_write, busy, req_ready}, {28'd0, 4'b0001});

    // Back-to-back with req_valid held: B must wait for the N+122 edge
    applyStimulus(8'd50, 7'd80, 3'b011, 1'b1);
    req_x      = 8'd51;
    req_height = 7'd20;
    req_colour = 3'b110;
    checkColumn(8'd50, 80, 3'b011);
    @(negedge clock);
    req_valid = 1'b0;
    checkColumn(8'd51, 20, 3'b110);

    // Reset during the write of row 50 aborts the column silently
    applyStimulus(8'd20, 7'd60, 3'b111, 1'b0);
    for (int i = 1; i <= 50; i++) @(negedge clock);
    checkOutput("row50_before_reset", {24'd0, vga_write, vga_y}, {24'd0, 1'b1, 7'd50});
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_outputs",
                {10'd0, req_ready, busy, done, vga_write, vga_x, vga_y, vga_colour},
                {10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0});
    reset = 1'b0;
    @(negedge clock);
    checkOutput("no_done_after_abort", {30'd0, done, vga_write}, 32'd0);

    // Fresh request draws normally from row 0
    applyStimulus(8'd77, 7'd100, 3'b101, 1'b0);
    checkColumn(8'd77, 100, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
